lsu_beat_unpacker: RTL and testbench

Downstream consumer of the frame-buffer LSU. On a start pulse it issues exactly one frame's worth of sequential read_enable pulses to the LSU. It absorbs the LSU's 1-cycle read latency in a 2-entry beat buffer. It unpacks each DATA_WIDTH beat into narrower pixel-group transfers on a valid/ready stream, marking start-of-frame and end-of-row for the next processing stage.

---
 rtl/lsu_beat_unpacker.sv | 142 ++++++++++++++
 tb/tb_lsu_beat_unpacker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_beat_unpacker.sv
// Frame reader: issues one frame of LSU reads, buffers beats (2 deep)
// and unpacks each beat into pixel-group stream transfers.
module lsu_beat_unpacker #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int BIT_WIDTH       = 8,
    parameter int PIXELS_PER_OUT  = 4,
    parameter int DATA_WIDTH      = PIXELS_PER_BEAT * BIT_WIDTH,
    parameter int OUT_WIDTH       = PIXELS_PER_OUT * BIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  lsu_read_enable,
    input  logic [DATA_WIDTH-1:0] lsu_read_data,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [OUT_WIDTH-1:0]  m_tdata,
    output logic                  m_tuser,
    output logic                  m_tlast
);

    localparam int BEATS  = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int SLICES = PIXELS_PER_BEAT / PIXELS_PER_OUT;
    localparam int XPR    = IMAGE_DIM / PIXELS_PER_OUT;
    localparam int TOTAL  = BEATS * SLICES;
    localparam int BW     = $clog2(BEATS + 1);
    localparam int TW     = $clog2(TOTAL + 1);
    localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int CW     = (XPR > 1) ? $clog2(XPR) : 1;

    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [TW-1:0] LAST_XFER  = TW'(TOTAL - 1);
    localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);
    localparam logic [CW-1:0] LAST_COL   = CW'(XPR - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [BW-1:0]         issued_q;
    logic [TW-1:0]         total_q;
    logic [CW-1:0]         col_q;
    logic [SW-1:0]         slice_q;
    logic [1:0]            occ_q;
    logic                  inflight_q;
    logic                  head_q;
    logic                  tail_q;
    logic [DATA_WIDTH-1:0] buf_q [2];

    logic [SLICES-1:0][OUT_WIDTH-1:0] head_slices;

    logic hs;
    logic pop;
    logic wr;
    logic rd_en;
    logic last_hs;

    // Outstanding = buffered + in flight; a read only goes out if it fits
    always_comb begin
        rd_en = (state_q == ISSUE) &&
                ((3'(occ_q) + 3'(inflight_q)) < 3'd2);
    end

    always_comb begin
        head_slices = buf_q[head_q];
        m_tvalid    = (occ_q != 2'd0);
        m_tdata     = head_slices[slice_q];
        m_tlast     = m_tvalid && (col_q == LAST_COL);
        busy        = (state_q == ISSUE) || (state_q == DRAIN);
        m_tuser     = busy && (total_q == '0);
        frame_done  = (state_q == DONE);
        lsu_read_enable = rd_en;
        hs          = m_tvalid && m_tready;
        pop         = hs && (slice_q == LAST_SLICE);
        wr          = inflight_q;
        last_hs     = hs && (total_q == LAST_XFER);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: if (rd_en && issued_q == LAST_BEAT) state_d = DRAIN;
            DRAIN: if (last_hs) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            total_q    <= '0;
            col_q      <= '0;
            slice_q    <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            if (state_q == IDLE && start) begin
                issued_q <= '0;
                total_q  <= '0;
                col_q    <= '0;
                slice_q  <= '0;
            end else begin
                if (rd_en) issued_q <= issued_q + 1'b1;
                if (hs) begin
                    total_q <= total_q + 1'b1;
                    slice_q <= pop ? '0 : slice_q + 1'b1;
                    col_q   <= (col_q == LAST_COL) ? '0 : col_q + 1'b1;
                end
            end
            // Read data lands one cycle after its strobe
            if (wr) begin
                buf_q[tail_q] <= lsu_read_data;
                tail_q        <= ~tail_q;
            end
            if (pop) head_q <= ~head_q;
            unique case ({wr, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_beat_unpacker.sv
// Directed bench for lsu_beat_unpacker: 32x32 frames with flow control,
// restart and reset cases, plus one full-size default frame.
module tb_lsu_beat_unpacker;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         start;
    logic         busy;
    logic         frame_done;
    logic         rd_en;
    logic [127:0] rdata;
    logic         m_tvalid;
    logic         m_tready;
    logic [31:0]  m_tdata;
    logic         m_tuser;
    logic         m_tlast;

    logic         b_start;
    logic         b_busy;
    logic         b_frame_done;
    logic         b_rd_en;
    logic [127:0] b_rdata;
    logic         b_tvalid;
    logic         b_tready;
    logic [31:0]  b_tdata;
    logic         b_tuser;
    logic         b_tlast;

    logic [5:0]   k;
    logic [13:0]  bk;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_beat_unpacker #(
        .PIXELS_PER_BEAT(16),
        .IMAGE_DIM(32),
        .BIT_WIDTH(8),
        .PIXELS_PER_OUT(4)
    ) u_dut (
        .clk(clk),
        .aresetn(aresetn),
        .start(start),
        .busy(busy),
        .frame_done(frame_done),
        .lsu_read_enable(rd_en),
        .lsu_read_data(rdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata(m_tdata),
        .m_tuser(m_tuser),
        .m_tlast(m_tlast)
    );

    lsu_beat_unpacker u_big (
        .clk(clk),
        .aresetn(aresetn),
        .start(b_start),
        .busy(b_busy),
        .frame_done(b_frame_done),
        .lsu_read_enable(b_rd_en),
        .lsu_read_data(b_rdata),
        .m_tvalid(b_tvalid),
        .m_tready(b_tready),
        .m_tdata(b_tdata),
        .m_tuser(b_tuser),
        .m_tlast(b_tlast)
    );

    function automatic logic [127:0] beat(input int kk);
        logic [127:0] b;
        for (int p = 0; p < 16; p++) b[8*p +: 8] = 8'((16*kk + p) % 256);
        return b;
    endfunction

    function automatic logic [31:0] xfer(input int j);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'((4*j + i) % 256);
        return d;
    endfunction

    // LSU models: 1-cycle latency, pointer wraps at end of frame
    always @(posedge clk) begin
        if (!aresetn) begin
            k  <= '0;
            bk <= '0;
        end else begin
            if (rd_en) begin
                rdata <= beat(int'(k));
                k     <= k + 6'd1;
            end
            if (b_rd_en) begin
                b_rdata <= beat(int'(bk));
                bk      <= bk + 14'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int duty, input int stall_at,
                             input int dup_at, input int rst_at);
        int j = 0;
        int reads = 0;
        int pops = 0;
        int cyc = 0;
        int stall_n = 0;
        int stall_reads = 0;
        int bubbles = 0;
        bit rdy;
        bit dup_done = 0;
        logic [31:0] hd;
        logic hu;
        logic hl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("first_read", rd_en, 1);
        check("first_valid_low", m_tvalid, 0);
        while (j < 256 && cyc < 20000) begin
            if (rst_at >= 0 && j == rst_at) break;
            if (rd_en) begin
                check("issue_gate", (reads - pops) < 2, 1);
                reads++;
            end
            if (stall_at >= 0 && j == stall_at && stall_n < 20) begin
                rdy = 1'b0;
                if (stall_n == 0) begin
                    hd = m_tdata;
                    hu = m_tuser;
                    hl = m_tlast;
                end else begin
                    check("stall_data", m_tdata, hd);
                    check("stall_user", m_tuser, hu);
                    check("stall_last", m_tlast, hl);
                end
                if (rd_en) stall_reads++;
                stall_n++;
            end else begin
                rdy = (duty >= 100) || ($urandom_range(99) < duty);
            end
            m_tready = rdy;
            if (m_tvalid && rdy) begin
                check("data", m_tdata, xfer(j));
                check("tuser", m_tuser, j == 0);
                check("tlast", m_tlast, (j % 8) == 7);
                if ((j % 4) == 3) pops++;
                j++;
            end else if (duty >= 100 && stall_at < 0 && j > 0) begin
                bubbles++;
            end
            start = 1'b0;
            if (dup_at >= 0 && j == dup_at && !dup_done) begin
                start = 1'b1;
                dup_done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        m_tready = 1'b0;
        start = 1'b0;
        if (rst_at >= 0) begin
            check("rst_reached", j, rst_at);
            aresetn = 1'b0;
            @(posedge clk);
            #1;
            check("rst_busy", busy, 0);
            check("rst_done", frame_done, 0);
            check("rst_rd", rd_en, 0);
            check("rst_valid", m_tvalid, 0);
            check("rst_user", m_tuser, 0);
            check("rst_last", m_tlast, 0);
            check("rst_state", u_dut.state_q, 0);
            @(negedge clk);
            aresetn = 1'b1;
            @(negedge clk);
            return;
        end
        check("xfer_count", j, 256);
        check("read_count", reads, 64);
        check("done_pulse", frame_done, 1);
        check("done_busy", busy, 0);
        if (duty >= 100 && stall_at < 0) check("bubbles", bubbles, 0);
        if (stall_at >= 0) begin
            check("stall_len", stall_n, 20);
            check("stall_reads", stall_reads <= 2, 1);
        end
        @(negedge clk);
        check("done_clear", frame_done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", m_tvalid, 0);
    endtask

    initial begin
        int bj = 0;
        int bread = 0;
        int nlast = 0;
        int bad = 0;
        int cyc = 0;
        aresetn  = 1'b0;
        start    = 1'b0;
        m_tready = 1'b0;
        b_start  = 1'b0;
        b_tready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_rd", rd_en, 0);
        check("reset_valid", m_tvalid, 0);
        check("reset_user", m_tuser, 0);
        check("reset_last", m_tlast, 0);
        aresetn = 1'b1;
        @(negedge clk);

        run_frame(100, -1, -1, -1);
        run_frame(30, -1, -1, -1);
        run_frame(100, 42, -1, -1);
        run_frame(100, -1, 50, -1);
        run_frame(100, -1, -1, -1);
        run_frame(100, -1, -1, 100);
        run_frame(100, -1, -1, -1);

        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_tready = 1'b1;
        while (bj < 65536 && cyc < 70000) begin
            if (b_rd_en) bread++;
            if (b_tvalid) begin
                if (b_tdata !== xfer(bj)) bad++;
                if (b_tuser !== (bj == 0)) bad++;
                if (b_tlast) begin
                    nlast++;
                    if ((bj % 128) != 127) bad++;
                end
                bj++;
            end
            @(negedge clk);
            cyc++;
        end
        b_tready = 1'b0;
        check("big_xfers", bj, 65536);
        check("big_reads", bread, 16384);
        check("big_tlast", nlast, 512);
        check("big_bad", bad, 0);
        check("big_done", b_frame_done, 1);
        @(negedge clk);
        check("big_idle", b_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
